// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } pc_seq_state_t;

  localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] PC_HALT_ADDR    = 32'h00000000;
  localparam logic [31:0] PC_STEP         = 32'd4;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection including the MIPS branch delay slot.
module pc_next_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pending_valid,
  input  logic [31:0] pending_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        next_pending_valid,
  output logic [31:0] next_pending_target
);

  always_comb begin
    next_pc             = pc + PC_STEP;
    next_pending_valid  = 1'b0;
    next_pending_target = pending_target;
    // A delay-slot instruction always redirects; its own branch request is dropped.
    if (pending_valid) begin
      next_pc = pending_target;
    end else if (branch_taken) begin
      next_pending_valid  = 1'b1;
      next_pending_target = branch_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch/execute sequencer for the multicycle MIPS core.
// Optional PC_TRACE_EN macro enables simulation-only PC/halt trace output.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = PC_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        instr_read,
  output logic [31:0] instr_address,
  input  logic        instr_waitrequest,
  output logic        exec_valid,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_out,
  output logic        active
);

  pc_seq_state_t state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          pending_valid_q, pending_valid_d;
  logic [31:0]   pending_target_q, pending_target_d;

  logic [31:0]   calc_next_pc;
  logic          calc_pending_valid;
  logic [31:0]   calc_pending_target;

  pc_next_calc u_next_calc (
    .pc                  (pc_q),
    .pending_valid       (pending_valid_q),
    .pending_target      (pending_target_q),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .next_pc             (calc_next_pc),
    .next_pending_valid  (calc_pending_valid),
    .next_pending_target (calc_pending_target)
  );

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;
    case (state_q)
      FETCH: begin
        if (!instr_waitrequest) state_d = EXEC;
      end
      EXEC: begin
        if (exec_done) begin
          pending_valid_d  = calc_pending_valid;
          pending_target_d = calc_pending_target;
          if (calc_next_pc == HALT_ADDR) begin
            state_d = HALTED;
            pc_d    = HALT_ADDR;
          end else begin
            state_d = FETCH;
            pc_d    = calc_next_pc;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= FETCH;
      pc_q             <= RESET_VECTOR;
      pending_valid_q  <= 1'b0;
      pending_target_q <= 32'h0;
    end else if (clk_enable) begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
    end
  end

  // Handshake outputs decode from state only, never from exec_done/waitrequest.
  assign instr_read    = (state_q == FETCH);
  assign exec_valid    = (state_q == EXEC);
  assign active        = (state_q != HALTED);
  assign pc_out        = (state_q == HALTED) ? HALT_ADDR : pc_q;
  assign instr_address = pc_out;

`ifdef PC_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && clk_enable && (state_q == EXEC) && exec_done) begin
      $display("CPU : PC : %h", pc_q);
      if (state_d == HALTED) $display("CPU : HALT");
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        instr_read;
  logic [31:0] instr_address;
  logic        instr_waitrequest;
  logic        exec_valid;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic        active;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .clk_enable        (clk_enable),
    .instr_read        (instr_read),
    .instr_address     (instr_address),
    .instr_waitrequest (instr_waitrequest),
    .exec_valid        (exec_valid),
    .exec_done         (exec_done),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .pc_out            (pc_out),
    .active            (active)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 = fetching, 1 = executing, 2 = halted.
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_tick();
    logic [31:0] nxt;
    if (!reset) begin
      m_phase = 0;
      m_pc    = 32'hBFC00000;
      m_pend.delete();
    end else if (clk_enable) begin
      if (m_phase == 0) begin
        if (!instr_waitrequest) m_phase = 1;
      end else if (m_phase == 1 && exec_done) begin
        if (m_pend.size() != 0) begin
          nxt = m_pend.pop_front();
        end else begin
          nxt = m_pc + 32'd4;
          if (branch_taken) m_pend.push_back(branch_target);
        end
        if (nxt == 32'h0) begin
          m_phase = 2;
          m_pc    = 32'h0;
        end else begin
          m_phase = 0;
          m_pc    = nxt;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("instr_read", {31'b0, instr_read}, {31'b0, m_phase == 0});
    check_eq("exec_valid", {31'b0, exec_valid}, {31'b0, m_phase == 1});
    check_eq("active", {31'b0, active}, {31'b0, m_phase != 2});
    check_eq("pc_out", pc_out, m_pc);
    check_eq("instr_address", instr_address, m_pc);
  endtask

  task automatic step(input logic rst, input logic en, input logic wr, input logic done,
                      input logic bt, input logic [31:0] tgt);
    reset             = rst;
    clk_enable        = en;
    instr_waitrequest = wr;
    exec_done         = done;
    branch_taken      = bt;
    branch_target     = tgt;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check_outputs();
  endtask

  // One zero-wait fetch followed by one exec_done.
  task automatic do_instr(input logic bt, input logic [31:0] tgt);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, bt, tgt);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    logic        rst, en, wr, done, bt;
    reset = 1'b0; clk_enable = 1'b1; instr_waitrequest = 1'b0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    m_phase = 0; m_pc = 32'hBFC00000;
    @(negedge clk);

    // Reset and first fetch
    do_reset();
    check_eq("reset_pc", pc_out, 32'hBFC00000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("first_exec_valid", {31'b0, exec_valid}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

    // Sequential steps then branch with delay slot, delay-slot branch ignored
    do_instr(1'b0, 32'h0);
    do_instr(1'b0, 32'h0);
    check_eq("seq_pc", pc_out, 32'hBFC0000C);
    do_instr(1'b0, 32'h0);
    do_instr(1'b1, 32'hBFC00100);
    check_eq("delay_slot_pc", pc_out, 32'hBFC00014);
    do_instr(1'b1, 32'h12345678);
    check_eq("branch_target_pc", pc_out, 32'hBFC00100);

    // Jump to halt address after its delay slot
    do_reset();
    for (int i = 0; i < 8; i++) do_instr(1'b0, 32'h0);
    check_eq("pre_jump_pc", pc_out, 32'hBFC00020);
    do_instr(1'b1, 32'h0);
    check_eq("halt_delay_active", {31'b0, active}, 32'd1);
    do_instr(1'b0, 32'h0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, i[0], i[1], 32'h40);
    check_eq("halted_active", {31'b0, active}, 32'd0);

    // Wait states, then clock-enable hold with exec_done asserted
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("exec_after_wait", {31'b0, exec_valid}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("hold_pc", pc_out, 32'hBFC00000);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

    // Reset while a delay slot is executing clears the pending target
    do_instr(1'b1, 32'hBFC00200);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    do_reset();
    do_instr(1'b0, 32'h0);
    check_eq("post_reset_pc", pc_out, 32'hBFC00004);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst  = !(($urandom_range(0, 299) == 0) || (m_phase == 2 && $urandom_range(0, 7) == 0));
      en   = ($urandom_range(0, 7) != 0);
      wr   = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 2) == 0);
      bt   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 15))
        0:       tgt = 32'h0;
        1:       tgt = 32'hFFFFFFF8;
        default: tgt = {$urandom() >> 2, 2'b00};
      endcase
      step(rst, en, wr, done, bt, tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
